sync_fifo_param: RTL and testbench
==================================

# sync_fifo_param

Parametrised synchronous FIFO, the next generation of the team's fixed 8-bit × 16-entry FIFO. It adds generic data width and depth, status flags, an occupancy count, overflow and underflow error pulses, and a selectable first-word-fall-through (FWFT) read mode. It sits between a single-clock producer and consumer as a drop-in buffer. The pointer outputs are retained for debug and bench visibility.

## Interface
- DATA_W, 8: data width in bits.
- DEPTH, 16: entries; power of two, ≥ 4. ADDR_W = log2(DEPTH).
- AF_THRESH, DEPTH-2: almost_full asserts when count ≥ AF_THRESH.
- AE_THRESH, 2: almost_empty asserts when count ≤ AE_THRESH.
- FWFT, 0: 0 = registered-read mode; 1 = first-word-fall-through mode.

- clk  in  1  sole clock; all state changes on its rising edge.
- rst  in  1  reset; one clock; reset is asynchronous and active-low.
- wr  in  1  write request.
- rd  in  1  read request.
- din  in  DATA_W  write data, sampled with wr.
- dout  out  DATA_W  read data.
- wrptr  out  ADDR_W  write address of the next entry written.
- rdptr  out  ADDR_W  read address of the next entry read.
- count  out  ADDR_W+1  occupancy, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count ≥ AF_THRESH.
- almost_empty  out  1  count ≤ AE_THRESH.
- overflow  out  1  one-cycle pulse: write rejected.
- underflow  out  1  one-cycle pulse: read rejected.

## Operation
- Internal pointers are ADDR_W+1 bits, with the MSB as the wrap bit. wrptr and rdptr outputs are the low ADDR_W bits. Pointers increment modulo 2·DEPTH.
- Write accept: wr && !full. Stores din at mem[wrptr] and increments wrptr.
- Read accept: rd && !empty. Increments rdptr.
- full and empty are evaluated on the current registered state, before the edge.
- count next value = count + write accept − read accept. The simultaneous accepted write and read leaves count unchanged.
- All flags are registered and derived from the next count value, so they move on the same edge as count.
- wr && full: the write is dropped, memory and wrptr are unchanged, and overflow pulses for one cycle. A simultaneous rd is still accepted. There is no write-through on full.
- rd && empty: no pointer change, and underflow pulses for one cycle. A simultaneous wr is still accepted.
- FWFT=0: dout is registered. It loads mem[rdptr] on the edge that accepts a read and holds its value otherwise, including after a rejected read.
- FWFT=1: dout = mem[rdptr] continuously. It is valid while !empty and the value is don't-care while empty. A read accept advances to the next word.
- Memory contents are not reset.

## Timing
- Reset (rst=0, asynchronous) gives:
  - pointers = 0, count = 0;
  - empty = 1, almost_empty = 1;
  - full = 0, almost_full = 0;
  - overflow = 0, underflow = 0;
  - dout = 0 (FWFT=0).
- Deassertion is sampled synchronously. The first write can be accepted on the first rising edge with rst=1.
- Reset mid-operation discards all contents immediately, without waiting for a clock edge. Requests present during reset are ignored and raise no error pulse.
- Write-to-flag latency: a write accepted at edge N clears empty and updates count during cycle N+1.
- FWFT=0 read latency: rd accepted at edge N gives data on dout during cycle N+1.
- FWFT=1 latency: a word written into an empty FIFO at edge N is on dout during cycle N+1.
- overflow and underflow are high only during the cycle after the offending edge. Back-to-back rejected requests give a continuous high.
- Wrap-around: after DEPTH writes, wrptr low bits return to 0. full is distinguished from empty by the pointer MSBs differing.

## Test plan
- Reset: apply rst=0 mid-stream with count=5. All outputs must reach their reset values without a clock edge. After release, empty=1 and count=0.
- Fill (DEPTH=16): 16 writes of 0x01..0x10 give full=1 and count=16, with almost_full from count=14. A 17th write gives an overflow pulse and count stays 16.
- Drain, FWFT=0: 16 reads return 0x01..0x10 in order, each one cycle after rd. A 17th read gives an underflow pulse, and dout holds 0x10.
- Simultaneous requests:
  - wr+rd at count=7: count stays 7 and the data order is preserved.
  - wr+rd when full: read accepted, count goes to 15, overflow=1.
  - wr+rd when empty: write accepted, count goes to 1, underflow=1.
- Wrap-around: 40 interleaved writes and reads with random 0–3 cycle gaps and occupancy ≤ 10. Every word matches the scoreboard, and wrptr/rdptr wrap past 15 to 0.
- FWFT=1: write 0xA5 into an empty FIFO. dout must be 0xA5 in the next cycle with no rd. After rd, empty=1.

Source files
------------

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, threshold flags,
// overflow/underflow pulses and a selectable first-word-fall-through read port.
// Pointers carry one extra wrap bit so a full FIFO and an empty FIFO differ
// even when their low address bits match.
module sync_fifo_param #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter bit FWFT      = 1'b0,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic              rd,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic [ADDR_W-1:0] wrptr,
  output logic [ADDR_W-1:0] rdptr,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow
);

  localparam int PW = ADDR_W + 1;
  localparam logic [ADDR_W:0] DEPTH_C = PW'(DEPTH);
  localparam logic [ADDR_W:0] AF_C    = PW'(AF_THRESH);
  localparam logic [ADDR_W:0] AE_C    = PW'(AE_THRESH);

  // Storage; contents are deliberately left unreset.
  logic [DATA_W-1:0] mem [DEPTH];

  // Registered control state.
  logic [ADDR_W:0] wr_ptr_p0;
  logic [ADDR_W:0] rd_ptr_p0;
  logic [ADDR_W:0] cnt_p0;
  logic            full_p0;
  logic            empty_p0;
  logic            afull_p0;
  logic            aempty_p0;
  logic            ovf_p0;
  logic            udf_p0;

  // Next-state terms.
  logic            wr_acc;
  logic            rd_acc;
  logic [ADDR_W:0] wr_ptr_nxt;
  logic [ADDR_W:0] rd_ptr_nxt;
  logic [ADDR_W:0] cnt_nxt;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;

  // Threshold helpers keep the flag equations readable.
  function automatic logic at_or_above(input logic [ADDR_W:0] c, input logic [ADDR_W:0] t);
    return (c >= t);
  endfunction

  function automatic logic at_or_below(input logic [ADDR_W:0] c, input logic [ADDR_W:0] t);
    return (c <= t);
  endfunction

  assign wr_addr = wr_ptr_p0[ADDR_W-1:0];
  assign rd_addr = rd_ptr_p0[ADDR_W-1:0];

  // Stage p0 input side: accept decisions use the pre-edge full/empty, and the
  // next occupancy is the wrap-aware pointer distance after this edge.
  always_comb begin
    wr_acc     = wr && !full_p0;
    rd_acc     = rd && !empty_p0;
    wr_ptr_nxt = wr_ptr_p0 + PW'(wr_acc);
    rd_ptr_nxt = rd_ptr_p0 + PW'(rd_acc);
    cnt_nxt    = wr_ptr_nxt - rd_ptr_nxt;
  end

  // Stage p0 register: pointers, count and all flags move on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_p0 <= '0;
      rd_ptr_p0 <= '0;
      cnt_p0    <= '0;
      full_p0   <= 1'b0;
      empty_p0  <= 1'b1;
      afull_p0  <= 1'b0;
      aempty_p0 <= 1'b1;
      ovf_p0    <= 1'b0;
      udf_p0    <= 1'b0;
    end else begin
      wr_ptr_p0 <= wr_ptr_nxt;
      rd_ptr_p0 <= rd_ptr_nxt;
      cnt_p0    <= cnt_nxt;
      full_p0   <= (cnt_nxt == DEPTH_C);
      empty_p0  <= (cnt_nxt == '0);
      afull_p0  <= at_or_above(cnt_nxt, AF_C);
      aempty_p0 <= at_or_below(cnt_nxt, AE_C);
      ovf_p0    <= wr && full_p0;
      udf_p0    <= rd && empty_p0;
    end
  end

  // Stage p0 storage write; requests seen while reset is held are ignored.
  always_ff @(posedge clk) begin
    if (rst && wr_acc) begin
      mem[wr_addr] <= din;
    end
  end

  generate
    if (FWFT) begin : g_fwft
      // Head word is presented combinationally; meaningless while empty.
      assign dout = mem[rd_addr];
    end else begin : g_reg
      logic [DATA_W-1:0] dout_p1;

      // Stage p1 read register: loads only on an accepted read, holds otherwise.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          dout_p1 <= '0;
        end else if (rd_acc) begin
          dout_p1 <= mem[rd_addr];
        end
      end

      assign dout = dout_p1;
    end
  endgenerate

  assign wrptr        = wr_addr;
  assign rdptr        = rd_addr;
  assign count        = cnt_p0;
  assign full         = full_p0;
  assign empty        = empty_p0;
  assign almost_full  = afull_p0;
  assign almost_empty = aempty_p0;
  assign overflow     = ovf_p0;
  assign underflow    = udf_p0;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: a registered-read instance and a FWFT instance
// share stimulus; a queue-based model predicts every output after each edge.
module tb_sync_fifo_param;

  localparam int DW = 8;
  localparam int DP = 16;

  logic          clk;
  logic          rst;
  logic          wr;
  logic          rd;
  logic [DW-1:0] din;

  logic [DW-1:0] dout0, dout1;
  logic [3:0]    wrptr0, rdptr0, wrptr1, rdptr1;
  logic [4:0]    count0, count1;
  logic          full0, empty0, af0, ae0, ov0, uf0;
  logic          full1, empty1, af1, ae1, ov1, uf1;

  sync_fifo_param #(.DATA_W(DW), .DEPTH(DP), .FWFT(1'b0)) dut0 (
    .clk(clk), .rst(rst), .wr(wr), .rd(rd), .din(din), .dout(dout0),
    .wrptr(wrptr0), .rdptr(rdptr0), .count(count0), .full(full0), .empty(empty0),
    .almost_full(af0), .almost_empty(ae0), .overflow(ov0), .underflow(uf0)
  );

  sync_fifo_param #(.DATA_W(DW), .DEPTH(DP), .FWFT(1'b1)) dut1 (
    .clk(clk), .rst(rst), .wr(wr), .rd(rd), .din(din), .dout(dout1),
    .wrptr(wrptr1), .rdptr(rdptr1), .count(count1), .full(full1), .empty(empty1),
    .almost_full(af1), .almost_empty(ae1), .overflow(ov1), .underflow(uf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: contents as a queue, pointers as accepted-transfer totals.
  logic [DW-1:0] q[$];
  int            m_wr_n;
  int            m_rd_n;
  logic [DW-1:0] m_dout;
  logic          m_ov;
  logic          m_uf;

  typedef struct {
    logic          wr;
    logic          rd;
    logic [DW-1:0] din;
    int            cnt;
    logic          full;
    logic          empty;
    logic          af;
    logic          ae;
    logic          ov;
    logic          uf;
    logic          chk_dout;
    logic [DW-1:0] dout;
  } vec_t;

  vec_t tbl[34];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_wr_n = 0;
    m_rd_n = 0;
    m_dout = '0;
    m_ov   = 1'b0;
    m_uf   = 1'b0;
  endtask

  task automatic check_model(input string tag);
    int sz;
    sz = q.size();
    chk({tag, ".count"},  32'(count0), 32'(sz));
    chk({tag, ".full"},   32'(full0),  32'(sz == DP));
    chk({tag, ".empty"},  32'(empty0), 32'(sz == 0));
    chk({tag, ".af"},     32'(af0),    32'(sz >= DP - 2));
    chk({tag, ".ae"},     32'(ae0),    32'(sz <= 2));
    chk({tag, ".ov"},     32'(ov0),    32'(m_ov));
    chk({tag, ".uf"},     32'(uf0),    32'(m_uf));
    chk({tag, ".wrptr"},  32'(wrptr0), 32'(m_wr_n % DP));
    chk({tag, ".rdptr"},  32'(rdptr0), 32'(m_rd_n % DP));
    chk({tag, ".dout"},   32'(dout0),  32'(m_dout));
    chk({tag, ".count1"}, 32'(count1), 32'(sz));
    if (sz > 0) chk({tag, ".dout1"}, 32'(dout1), 32'(q[0]));
  endtask

  // One clock of stimulus; the model applies the FIFO rules from the pre-edge size.
  task automatic step(input logic w, input logic r, input logic [DW-1:0] d, input string tag);
    int pre;
    logic wa, ra;
    wr  = w;
    rd  = r;
    din = d;
    @(posedge clk);
    pre  = q.size();
    wa   = w && (pre < DP);
    ra   = r && (pre > 0);
    m_ov = w && (pre == DP);
    m_uf = r && (pre == 0);
    if (ra) begin
      m_dout = q.pop_front();
      m_rd_n++;
    end
    if (wa) begin
      q.push_back(d);
      m_wr_n++;
    end
    #1;
    check_model(tag);
  endtask

  task automatic drain();
    int guard = 0;
    while (q.size() > 0 && guard < 40) begin
      step(1'b0, 1'b1, '0, "drain");
      guard++;
    end
    chk("drain_done", 32'(q.size()), 32'd0);
  endtask

  initial begin
    int nw, nr, it;
    logic w, r;
    logic [3:0] pw, pr;
    logic saw_w, saw_r;

    // Fill with 0x01..0x10, one rejected write, drain, one rejected read.
    for (int i = 0; i < 34; i++) begin
      tbl[i] = '{wr: 1'b0, rd: 1'b0, din: '0, cnt: 0, full: 1'b0, empty: 1'b0,
                 af: 1'b0, ae: 1'b0, ov: 1'b0, uf: 1'b0, chk_dout: 1'b0, dout: '0};
      if (i < 16) begin
        tbl[i].wr  = 1'b1;
        tbl[i].din = DW'(i + 1);
        tbl[i].cnt = i + 1;
      end else if (i == 16) begin
        tbl[i].wr  = 1'b1;
        tbl[i].din = 8'h11;
        tbl[i].cnt = 16;
        tbl[i].ov  = 1'b1;
      end else if (i < 33) begin
        tbl[i].rd       = 1'b1;
        tbl[i].cnt      = 15 - (i - 17);
        tbl[i].chk_dout = 1'b1;
        tbl[i].dout     = DW'(i - 16);
      end else begin
        tbl[i].rd       = 1'b1;
        tbl[i].cnt      = 0;
        tbl[i].uf       = 1'b1;
        tbl[i].chk_dout = 1'b1;
        tbl[i].dout     = 8'h10;
      end
      tbl[i].full  = (tbl[i].cnt == 16);
      tbl[i].empty = (tbl[i].cnt == 0);
      tbl[i].af    = (tbl[i].cnt >= 14);
      tbl[i].ae    = (tbl[i].cnt <= 2);
    end

    // Power-on reset.
    rst = 1'b0; wr = 1'b0; rd = 1'b0; din = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_model("por");
    chk("por.empty_lit", 32'(empty0), 32'd1);
    chk("por.ae_lit",    32'(ae0),    32'd1);
    rst = 1'b1;

    for (int i = 0; i < 34; i++) begin
      step(tbl[i].wr, tbl[i].rd, tbl[i].din, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d.cnt", i),   32'(count0), 32'(tbl[i].cnt));
      chk($sformatf("tbl%0d.full", i),  32'(full0),  32'(tbl[i].full));
      chk($sformatf("tbl%0d.empty", i), 32'(empty0), 32'(tbl[i].empty));
      chk($sformatf("tbl%0d.af", i),    32'(af0),    32'(tbl[i].af));
      chk($sformatf("tbl%0d.ae", i),    32'(ae0),    32'(tbl[i].ae));
      chk($sformatf("tbl%0d.ov", i),    32'(ov0),    32'(tbl[i].ov));
      chk($sformatf("tbl%0d.uf", i),    32'(uf0),    32'(tbl[i].uf));
      if (tbl[i].chk_dout) chk($sformatf("tbl%0d.dout", i), 32'(dout0), 32'(tbl[i].dout));
    end

    // wr+rd when full: read accepted, write dropped.
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, DW'(8'h40 + i), "fill2");
    step(1'b1, 1'b1, 8'hEE, "wrrd_full");
    chk("wrrd_full.cnt", 32'(count0), 32'd15);
    chk("wrrd_full.ov",  32'(ov0),    32'd1);
    chk("wrrd_full.dout", 32'(dout0), 32'h40);
    drain();

    // wr+rd when empty: write accepted, read rejected.
    step(1'b1, 1'b1, 8'h5A, "wrrd_empty");
    chk("wrrd_empty.cnt", 32'(count0), 32'd1);
    chk("wrrd_empty.uf",  32'(uf0),    32'd1);
    drain();
    chk("wrrd_empty.data", 32'(dout0), 32'h5A);

    // wr+rd at count=7: occupancy steady, order kept.
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, DW'(8'h60 + i), "fill7");
    step(1'b1, 1'b1, 8'h67, "wrrd_7");
    chk("wrrd_7.cnt",  32'(count0), 32'd7);
    chk("wrrd_7.dout", 32'(dout0),  32'h60);
    drain();

    // Asynchronous reset mid-stream with five entries held.
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, DW'(8'h31 + i), "pre_rst");
    step(1'b0, 1'b1, '0, "pre_rst_rd");
    chk("pre_rst.cnt", 32'(count0), 32'd5);
    rst = 1'b0;
    #2;
    model_reset();
    check_model("async_rst");
    chk("async_rst.dout_lit", 32'(dout0), 32'd0);
    wr = 1'b1; rd = 1'b1; din = 8'hCC;
    @(posedge clk);
    #1;
    check_model("rst_held");
    rst = 1'b1; wr = 1'b0; rd = 1'b0;
    step(1'b1, 1'b0, 8'h77, "first_wr");
    chk("first_wr.cnt", 32'(count0), 32'd1);
    drain();

    // Randomised interleave with wrap-around, occupancy capped at 10.
    nw = 0; nr = 0; it = 0; saw_w = 1'b0; saw_r = 1'b0;
    while ((nw < 40 || nr < 40) && it < 1000) begin
      w  = (nw < 40) && (q.size() < 10) && ($urandom_range(0, 1) == 1);
      r  = (nr < 40) && (q.size() > 0)  && ($urandom_range(0, 1) == 1);
      pw = wrptr0;
      pr = rdptr0;
      step(w, r, DW'($urandom), "rand");
      if (w) nw++;
      if (r) nr++;
      if (pw == 4'd15 && wrptr0 == 4'd0) saw_w = 1'b1;
      if (pr == 4'd15 && rdptr0 == 4'd0) saw_r = 1'b1;
      repeat ($urandom_range(0, 3)) step(1'b0, 1'b0, '0, "gap");
      it++;
    end
    chk("rand.done",   32'((nw == 40) && (nr == 40)), 32'd1);
    chk("rand.wrwrap", 32'(saw_w), 32'd1);
    chk("rand.rdwrap", 32'(saw_r), 32'd1);
    drain();

    // FWFT: word visible the cycle after it is written, without a read.
    step(1'b1, 1'b0, 8'hA5, "fwft_wr");
    chk("fwft.dout",   32'(dout1),  32'hA5);
    chk("fwft.empty",  32'(empty1), 32'd0);
    step(1'b0, 1'b0, '0, "fwft_hold");
    chk("fwft.hold",   32'(dout1),  32'hA5);
    step(1'b0, 1'b1, '0, "fwft_rd");
    chk("fwft.empty_after", 32'(empty1), 32'd1);
    chk("fwft.uf", 32'(uf1), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
